// File: rtl/rat_irq_pkg.sv
// Shared constants and types for the RAT interrupt front-end.
package rat_irq_pkg;
    localparam int          N_SRC_DEFAULT = 4;
    localparam logic [7:0]  MASK_PORT_ID  = 8'h20;
    localparam logic [7:0]  CLR_PORT_ID   = 8'h21;

    typedef logic [7:0] irq_id_t;

    localparam irq_id_t     SPURIOUS_ID   = 8'hFF;
endpackage

// File: rtl/rat_irq_controller_if.sv
// CPU OUT-port bus seen by the interrupt controller (strobe, address, data).
interface rat_irq_controller_if;
    logic       IO_STRB;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;

    modport master (output IO_STRB, output PORT_ID, output OUT_PORT);
    modport slave  (input  IO_STRB, input  PORT_ID, input  OUT_PORT);
endinterface

// File: rtl/rat_irq_edge.sv
// Per-source synchroniser, optional debounce filter (RAT_IRQ_DEBOUNCE_EN) and rising-edge detect.
module rat_irq_edge
    import rat_irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_irq,
    output logic o_edge,
    output logic o_level
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_irq;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
        end
    end

`ifdef RAT_IRQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;

    // Filtered level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (r_sync2 == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt  <= '0;
            r_filt <= r_sync2;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    assign o_level = w_level;
    assign o_edge  = w_level & ~r_prev;
endmodule

// File: rtl/rat_irq_controller.sv
// RAT interrupt front-end: pending/mask registers, I flag, priority encode and ack capture.
// Optional input debounce is enabled with the RAT_IRQ_DEBOUNCE_EN macro.
module rat_irq_controller
    import rat_irq_pkg::*;
#(
    parameter int         N_SRC           = N_SRC_DEFAULT,
    parameter logic [7:0] MASK_PORT_ID    = rat_irq_pkg::MASK_PORT_ID,
    parameter logic [7:0] CLR_PORT_ID     = rat_irq_pkg::CLR_PORT_ID,
    parameter int         DEBOUNCE_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [N_SRC-1:0]      IRQ_IN,
    input  logic                  I_SET,
    input  logic                  I_CLR,
    input  logic                  INT_ACK,
    rat_irq_controller_if.slave   io_bus,
    output logic                  INTERRUPT,
    output logic                  I_FLAG,
    output logic [N_SRC-1:0]      PENDING,
    output irq_id_t               IRQ_LAST
);
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask;
    logic             r_iflag;
    irq_id_t          r_irq_last;

    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_level;
    logic [N_SRC-1:0] w_active;
    logic [N_SRC-1:0] w_ack_oh;
    logic [N_SRC-1:0] w_pend_nxt;
    irq_id_t          w_active_id;
    logic             w_any;
    logic             w_wr_mask;
    logic             w_wr_clr;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        rat_irq_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_edge (
            .CLK     (CLK),
            .RESET   (RESET),
            .i_irq   (IRQ_IN[g]),
            .o_edge  (w_edge[g]),
            .o_level (w_level[g])
        );
    end

    assign w_wr_mask = io_bus.IO_STRB && (io_bus.PORT_ID == MASK_PORT_ID);
    assign w_wr_clr  = io_bus.IO_STRB && (io_bus.PORT_ID == CLR_PORT_ID);
    assign w_active  = r_pending & r_mask;
    assign w_any     = |w_active;

    // Scan high to low so the lowest active index is the one left standing.
    always_comb begin
        w_active_id = '0;
        w_ack_oh    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_active_id = irq_id_t'(i);
                w_ack_oh    = '0;
                w_ack_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_pend_nxt = r_pending;
        if (w_wr_clr)
            w_pend_nxt = w_pend_nxt & ~io_bus.OUT_PORT[N_SRC-1:0];
        if (INT_ACK)
            w_pend_nxt = w_pend_nxt & ~w_ack_oh;
        w_pend_nxt = w_pend_nxt | w_edge;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pending  <= '0;
            r_mask     <= '1;
            r_iflag    <= 1'b0;
            r_irq_last <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            if (w_wr_mask)
                r_mask <= io_bus.OUT_PORT[N_SRC-1:0];
            if (I_CLR)
                r_iflag <= 1'b0;
            else if (I_SET)
                r_iflag <= 1'b1;
            if (INT_ACK)
                r_irq_last <= w_any ? w_active_id : SPURIOUS_ID;
        end
    end

    assign INTERRUPT = r_iflag & w_any;
    assign I_FLAG    = r_iflag;
    assign PENDING   = r_pending;
    assign IRQ_LAST  = r_irq_last;
endmodule

// File: tb/tb_rat_irq_controller.sv
// Directed bench for rat_irq_controller; covers the debounce build when RAT_IRQ_DEBOUNCE_EN is defined.
module tb_rat_irq_controller;
`ifdef RAT_IRQ_DEBOUNCE_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 3;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] IRQ_IN;
    logic       I_SET, I_CLR, INT_ACK;
    logic       INTERRUPT, I_FLAG;
    logic [3:0] PENDING;
    logic [7:0] IRQ_LAST;
    int         checks = 0;
    int         errors = 0;

    rat_irq_controller_if bus();

    rat_irq_controller #(.N_SRC(4), .DEBOUNCE_CYCLES(16)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IRQ_IN    (IRQ_IN),
        .I_SET     (I_SET),
        .I_CLR     (I_CLR),
        .INT_ACK   (INT_ACK),
        .io_bus    (bus),
        .INTERRUPT (INTERRUPT),
        .I_FLAG    (I_FLAG),
        .PENDING   (PENDING),
        .IRQ_LAST  (IRQ_LAST)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic out_write(input logic [7:0] port, input logic [7:0] data);
        bus.IO_STRB  = 1'b1;
        bus.PORT_ID  = port;
        bus.OUT_PORT = data;
        tick();
        bus.IO_STRB  = 1'b0;
    endtask

    task automatic pulse_iset();
        I_SET = 1'b1; tick(); I_SET = 1'b0;
    endtask

    task automatic ack_iclr();
        INT_ACK = 1'b1; I_CLR = 1'b1; tick(); INT_ACK = 1'b0; I_CLR = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; tick(2); RESET = 1'b0;
        checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL reset_pending got %b exp 0000", PENDING); end
        checks++; if (I_FLAG !== 1'b0) begin errors++; $display("FAIL reset_iflag got %b exp 0", I_FLAG); end
        checks++; if (IRQ_LAST !== 8'h00) begin errors++; $display("FAIL reset_irq_last got %h exp 00", IRQ_LAST); end
        checks++; if (INTERRUPT !== 1'b0) begin errors++; $display("FAIL reset_interrupt got %b exp 0", INTERRUPT); end
    endtask

    task automatic test_single();
        pulse_iset();
        checks++; if (I_FLAG !== 1'b1) begin errors++; $display("FAIL iset got %b exp 1", I_FLAG); end
        IRQ_IN[0] = 1'b1;
        tick(LAT - 1);
        checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL single_early got %b exp 0000", PENDING); end
        tick();
        checks++; if (PENDING !== 4'b0001) begin errors++; $display("FAIL single_pend got %b exp 0001", PENDING); end
        checks++; if (INTERRUPT !== 1'b1) begin errors++; $display("FAIL single_int got %b exp 1", INTERRUPT); end
        ack_iclr();
        checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL single_ack_pend got %b exp 0000", PENDING); end
        checks++; if (IRQ_LAST !== 8'h00) begin errors++; $display("FAIL single_ack_last got %h exp 00", IRQ_LAST); end
        checks++; if (INTERRUPT !== 1'b0) begin errors++; $display("FAIL single_ack_int got %b exp 0", INTERRUPT); end
        tick(LAT + 4);
        checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL level_one_edge got %b exp 0000", PENDING); end
        IRQ_IN[0] = 1'b0;
        tick(LAT + 2);
    endtask

    task automatic test_priority();
        pulse_iset();
        IRQ_IN[3] = 1'b1; IRQ_IN[1] = 1'b1;
        tick(LAT);
        checks++; if (PENDING !== 4'b1010) begin errors++; $display("FAIL prio_pend got %b exp 1010", PENDING); end
        ack_iclr();
        checks++; if (IRQ_LAST !== 8'h01) begin errors++; $display("FAIL prio_last1 got %h exp 01", IRQ_LAST); end
        checks++; if (PENDING !== 4'b1000) begin errors++; $display("FAIL prio_pend1 got %b exp 1000", PENDING); end
        checks++; if (INTERRUPT !== 1'b0) begin errors++; $display("FAIL prio_int_off got %b exp 0", INTERRUPT); end
        pulse_iset();
        checks++; if (INTERRUPT !== 1'b1) begin errors++; $display("FAIL prio_reraise got %b exp 1", INTERRUPT); end
        ack_iclr();
        checks++; if (IRQ_LAST !== 8'h03) begin errors++; $display("FAIL prio_last2 got %h exp 03", IRQ_LAST); end
        checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL prio_pend2 got %b exp 0000", PENDING); end
        IRQ_IN[3] = 1'b0; IRQ_IN[1] = 1'b0;
        tick(LAT + 2);
    endtask

    task automatic test_mask();
        pulse_iset();
        out_write(8'h20, 8'h0D);
        IRQ_IN[1] = 1'b1;
        tick(LAT);
        checks++; if (PENDING !== 4'b0010) begin errors++; $display("FAIL mask_pend got %b exp 0010", PENDING); end
        checks++; if (INTERRUPT !== 1'b0) begin errors++; $display("FAIL mask_int got %b exp 0", INTERRUPT); end
        out_write(8'h20, 8'h0F);
        checks++; if (INTERRUPT !== 1'b1) begin errors++; $display("FAIL unmask_int got %b exp 1", INTERRUPT); end
        out_write(8'h22, 8'h02);
        checks++; if (PENDING !== 4'b0010) begin errors++; $display("FAIL other_port got %b exp 0010", PENDING); end
        bus.PORT_ID = 8'h21; bus.OUT_PORT = 8'h02; tick();
        checks++; if (PENDING !== 4'b0010) begin errors++; $display("FAIL no_strobe got %b exp 0010", PENDING); end
        out_write(8'h21, 8'h02);
        checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL w1c got %b exp 0000", PENDING); end
        checks++; if (INTERRUPT !== 1'b0) begin errors++; $display("FAIL w1c_int got %b exp 0", INTERRUPT); end
        IRQ_IN[1] = 1'b0;
        tick(LAT + 2);
    endtask

    task automatic test_collision();
        IRQ_IN[2] = 1'b1;
        tick(LAT - 1);
        out_write(8'h21, 8'h04);
        checks++; if (PENDING !== 4'b0100) begin errors++; $display("FAIL set_wins got %b exp 0100", PENDING); end
        I_SET = 1'b1; I_CLR = 1'b1; tick(); I_SET = 1'b0; I_CLR = 1'b0;
        checks++; if (I_FLAG !== 1'b0) begin errors++; $display("FAIL clr_wins got %b exp 0", I_FLAG); end
        out_write(8'h21, 8'h04);
        checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL coll_clear got %b exp 0000", PENDING); end
        IRQ_IN[2] = 1'b0;
        tick(LAT + 2);
    endtask

    task automatic test_spurious_and_reset();
        out_write(8'h20, 8'h0B);
        IRQ_IN[2] = 1'b1;
        tick(LAT);
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
        checks++; if (IRQ_LAST !== 8'hFF) begin errors++; $display("FAIL spurious_last got %h exp ff", IRQ_LAST); end
        checks++; if (PENDING !== 4'b0100) begin errors++; $display("FAIL spurious_pend got %b exp 0100", PENDING); end
        pulse_iset();
        IRQ_IN[0] = 1'b1;
        tick();
        RESET = 1'b1; tick(); IRQ_IN = 4'b0000; tick(); RESET = 1'b0;
        checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL rst_mid_pend got %b exp 0000", PENDING); end
        checks++; if (IRQ_LAST !== 8'h00) begin errors++; $display("FAIL rst_mid_last got %h exp 00", IRQ_LAST); end
        checks++; if (I_FLAG !== 1'b0) begin errors++; $display("FAIL rst_mid_iflag got %b exp 0", I_FLAG); end
        tick(LAT + 2);
        checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL rst_inflight got %b exp 0000", PENDING); end
        pulse_iset();
        IRQ_IN[2] = 1'b1;
        tick(LAT);
        checks++; if (INTERRUPT !== 1'b1) begin errors++; $display("FAIL rst_mask_ones got %b exp 1", INTERRUPT); end
        IRQ_IN[2] = 1'b0;
        out_write(8'h21, 8'h0F);
        tick(LAT + 2);
    endtask

`ifdef RAT_IRQ_DEBOUNCE_EN
    task automatic test_debounce();
        IRQ_IN[1] = 1'b1; tick(10); IRQ_IN[1] = 1'b0;
        tick(40);
        checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL glitch got %b exp 0000", PENDING); end
        IRQ_IN[1] = 1'b1;
        tick(LAT - 1);
        checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL deb_early got %b exp 0000", PENDING); end
        tick();
        checks++; if (PENDING !== 4'b0010) begin errors++; $display("FAIL deb_pend got %b exp 0010", PENDING); end
        IRQ_IN[1] = 1'b0;
        tick(40);
        checks++; if (PENDING !== 4'b0010) begin errors++; $display("FAIL deb_once got %b exp 0010", PENDING); end
    endtask
`endif

    initial begin
        RESET = 1'b1; IRQ_IN = 4'b0000;
        I_SET = 1'b0; I_CLR = 1'b0; INT_ACK = 1'b0;
        bus.IO_STRB = 1'b0; bus.PORT_ID = 8'h00; bus.OUT_PORT = 8'h00;
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_collision();
        test_spurious_and_reset();
`ifdef RAT_IRQ_DEBOUNCE_EN
        test_debounce();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
